// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: blank code, idle patterns,
// hex glyph table and the slot state type.
package seg_pkg;

  localparam logic [4:0] BLANK_CODE = 5'd16;
  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [3:0] AN_OFF     = 4'hF;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam logic [6:0] HEX_GLYPH [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2,
    SLOT3 = 2'd3
  } slot_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 5-bit digit code to active-low segment pattern.
// Codes 16..31 produce a blank digit.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_OFF;
    if (!code[4]) seg_n = HEX_GLYPH[code[3:0]];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode display driver with per-frame input
// snapshot and anode dead time at the start of every digit slot.
module seg7_scan_driver
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 500,
  parameter int CNT_W       = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [4:0] one_code,
  input  logic [4:0] ten_code,
  input  logic [4:0] hund_code,
  input  logic [4:0] thou_code,
  input  logic [3:0] dp_mask,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick,
  output logic [1:0] slot_dbg
);

  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic             dead;
  logic             frame_end;
  slot_e            slot, slot_nxt;
  logic [4:0]       snap [0:3];
  logic [3:0]       snap_dp;
  logic [6:0]       cur_seg;

  assign wrap      = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign dead      = (cnt < CNT_W'(DEAD_CYCLES));
  assign frame_end = wrap && (slot == SLOT3);
  assign slot_dbg  = slot;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (wrap) cnt <= '0;
    else           cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) slot <= SLOT0;
    else       slot <= slot_nxt;
  end

  always_comb begin
    slot_nxt = slot;
    if (wrap) begin
      case (slot)
        SLOT0:   slot_nxt = SLOT1;
        SLOT1:   slot_nxt = SLOT2;
        SLOT2:   slot_nxt = SLOT3;
        SLOT3:   slot_nxt = SLOT0;
        default: slot_nxt = SLOT0;
      endcase
    end
  end

  // All four codes are captured together so a frame never mixes old and new values
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap[0] <= BLANK_CODE;
      snap[1] <= BLANK_CODE;
      snap[2] <= BLANK_CODE;
      snap[3] <= BLANK_CODE;
      snap_dp <= 4'b0000;
    end else if (frame_end) begin
      snap[0] <= one_code;
      snap[1] <= ten_code;
      snap[2] <= hund_code;
      snap[3] <= thou_code;
      snap_dp <= dp_mask;
    end
  end

  seg7_decode u_decode (
    .code  (snap[slot]),
    .seg_n (cur_seg)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (dead || !enable) begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b0001 << slot);
        seg <= cur_seg;
        dp  <= ~snap_dp[slot];
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with an 8-cycle slot and 2-cycle dead time:
// frame-level reference model, per-cycle compare, and directed literal checks.
module tb_seg7_scan_driver;

  localparam int RD = 8;
  localparam int DC = 2;
  localparam int FRAME = 4 * RD;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [4:0] one_code, ten_code, hund_code, thou_code;
  logic [3:0] dp_mask;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;
  logic [1:0] slot_dbg;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(.REFRESH_DIV(RD), .DEAD_CYCLES(DC), .CNT_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .one_code   (one_code),
    .ten_code   (ten_code),
    .hund_code  (hund_code),
    .thou_code  (thou_code),
    .dp_mask    (dp_mask),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick),
    .slot_dbg   (slot_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Glyphs written straight from the display table, {g,f,e,d,c,b,a}, active-low
  function automatic logic [6:0] glyph(input logic [4:0] code);
    case (code)
      5'd0:  glyph = 7'b1000000;
      5'd1:  glyph = 7'b1111001;
      5'd2:  glyph = 7'b0100100;
      5'd3:  glyph = 7'b0110000;
      5'd4:  glyph = 7'b0011001;
      5'd5:  glyph = 7'b0010010;
      5'd6:  glyph = 7'b0000010;
      5'd7:  glyph = 7'b1111000;
      5'd8:  glyph = 7'b0000000;
      5'd9:  glyph = 7'b0010000;
      5'd10: glyph = 7'b0001000;
      5'd11: glyph = 7'b0000011;
      5'd12: glyph = 7'b1000110;
      5'd13: glyph = 7'b0100001;
      5'd14: glyph = 7'b0000110;
      5'd15: glyph = 7'b0001110;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  localparam logic [12:0] IDLE = {4'hF, 7'h7F, 1'b1, 1'b0};

  // Reference model: cycle number since reset release determines the slot and
  // position inside it; the shown codes are whatever was latched at the last frame end.
  logic [12:0] exp_q[$];
  int          n_cyc = 0;
  logic [4:0]  m_code [0:3];
  logic [3:0]  m_dp;

  always @(posedge clock) begin
    int s, pos, digit;
    logic [3:0] an_e;
    logic [12:0] e;
    if (reset) begin
      n_cyc = 0;
      for (int i = 0; i < 4; i++) m_code[i] = 5'd16;
      m_dp = 4'b0000;
      exp_q.push_back(IDLE);
    end else begin
      s = n_cyc;
      n_cyc++;
      pos   = s % RD;
      digit = (s / RD) % 4;
      if (pos < DC || !enable) begin
        e = IDLE;
      end else begin
        for (int i = 0; i < 4; i++) an_e[i] = (i != digit);
        e = {an_e, glyph(m_code[digit]), !m_dp[digit], 1'b0};
      end
      e[0] = ((s % FRAME) == FRAME - 1);
      exp_q.push_back(e);
      if ((s % FRAME) == FRAME - 1) begin
        m_code[0] = one_code;
        m_code[1] = ten_code;
        m_code[2] = hund_code;
        m_code[3] = thou_code;
        m_dp      = dp_mask;
      end
    end
  end

  // Scoreboard compare, sampled on the falling edge
  always @(negedge clock) begin
    logic [12:0] e;
    if (reset) begin
      exp_q.delete();
      chk("reset_hold", {an, seg, dp, frame_tick}, IDLE);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cycle", {an, seg, dp, frame_tick}, e);
      chk("one_anode", ($countones(~an) <= 1), 1);
    end
  end

  // driver tasks
  int cur_k = 0;
  int lit_cnt [0:3];

  task automatic wait_ft();
    int budget = 100;
    while (budget > 0) begin
      @(negedge clock);
      budget--;
      if (frame_tick === 1'b1) break;
    end
    chk("ft_seen", frame_tick, 1);
    cur_k = 0;
  endtask

  task automatic goto_k(input int k);
    while (cur_k < k) begin
      @(negedge clock);
      cur_k++;
    end
    if (k == FRAME) begin
      chk("ft_period", frame_tick, 1);
      cur_k = 0;
    end
  endtask

  task automatic count_frame();
    for (int i = 0; i < 4; i++) lit_cnt[i] = 0;
    while (cur_k < FRAME) begin
      @(negedge clock);
      cur_k++;
      for (int i = 0; i < 4; i++) if (an[i] === 1'b0) lit_cnt[i]++;
      if (cur_k < FRAME) chk("ft_quiet", frame_tick, 0);
    end
    chk("ft_period", frame_tick, 1);
    cur_k = 0;
  endtask

  task automatic set_codes(input int a, input int b, input int c, input int d);
    one_code  = 5'(a);
    ten_code  = 5'(b);
    hund_code = 5'(c);
    thou_code = 5'(d);
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    set_codes(0, 0, 0, 0);
    dp_mask = 4'b0000;
    repeat (3) @(negedge clock);
    chk("reset_an", an, 4'hF);
    chk("reset_seg", seg, 7'h7F);
    chk("reset_dp", dp, 1);
    chk("reset_ft", frame_tick, 0);
    reset = 1'b0;
    set_codes(1, 2, 3, 4);

    // first frame with 1,2,3,4
    wait_ft();
    goto_k(3);
    chk("slot0_an", an, 4'b1110);
    chk("slot0_seg", seg, 7'b1111001);
    goto_k(27);
    chk("slot3_an", an, 4'b0111);
    chk("slot3_seg", seg, 7'b0011001);
    chk("slot3_dp", dp, 1);
    goto_k(FRAME);
    count_frame();
    for (int i = 0; i < 4; i++) chk("lit_6of8", lit_cnt[i], 6);

    // mid-frame changes stay invisible until the next snapshot
    goto_k(1);
    ten_code = 5'd9;
    goto_k(11);
    chk("ten_held", seg, 7'b0100100);
    goto_k(19);
    one_code = 5'd15;
    goto_k(FRAME);
    goto_k(3);
    chk("one_new_an", an, 4'b1110);
    chk("one_new_seg", seg, 7'b0001110);
    goto_k(11);
    chk("ten_new_seg", seg, 7'b0010000);
    goto_k(FRAME);

    // blank code still honours the decimal point
    thou_code = 5'd16;
    dp_mask = 4'b1000;
    goto_k(FRAME);
    goto_k(27);
    chk("blank_an", an, 4'b0111);
    chk("blank_seg", seg, 7'h7F);
    chk("blank_dp", dp, 0);
    goto_k(FRAME);

    // one full frame disabled
    enable = 1'b0;
    count_frame();
    chk("dis_lit", lit_cnt[0] + lit_cnt[1] + lit_cnt[2] + lit_cnt[3], 0);
    enable = 1'b1;

    // walk every code 0..31 through the display
    for (int f = 0; f < 8; f++) begin
      set_codes(4 * f, 4 * f + 1, 4 * f + 2, 4 * f + 3);
      dp_mask = 4'($urandom_range(0, 15));
      goto_k(FRAME);
    end

    // random inputs changing at random points inside frames
    for (int f = 0; f < 4; f++) begin
      for (int k = 1; k <= FRAME; k++) begin
        goto_k(k);
        if ($urandom_range(0, 3) == 0)
          set_codes($urandom_range(0, 31), $urandom_range(0, 31),
                    $urandom_range(0, 31), $urandom_range(0, 31));
        if ($urandom_range(0, 5) == 0) dp_mask = 4'($urandom_range(0, 15));
        enable = ($urandom_range(0, 7) != 0);
      end
    end
    enable = 1'b1;

    // asynchronous reset in the middle of a lit slot
    goto_k(13);
    #1 reset = 1'b1;
    #1;
    chk("async_an", an, 4'hF);
    chk("async_seg", seg, 7'h7F);
    chk("async_dp", dp, 1);
    chk("async_ft", frame_tick, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    set_codes(8, 8, 8, 8);
    wait_ft();
    count_frame();
    for (int i = 0; i < 4; i++) chk("post_rst_lit", lit_cnt[i], 6);
    repeat (4) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual running expected finished", $time);
    $fatal(1, "watchdog");
  end

endmodule
